frame_ctrl: RTL and testbench
=============================

FRAME_CTRL -- requirements
Module: frame_ctrl

Interface
REQ-001 SHALL have parameter RES_W, default 16, width of resolution fields and pixel/line counters.
REQ-002 SHALL have parameter CNT_W, default 32, width of statistics counters.
REQ-003 SHALL have port aclk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port areset  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port enable  in  1  permits new frames to start.
REQ-006 SHALL have port frame_req  in  1  single-cycle frame request from the timing generator.
REQ-007 SHALL have ports cfg_h_res, cfg_v_res  in  RES_W  requested resolution.
REQ-008 SHALL have ports gen_h_res, gen_v_res  out  RES_W  latched resolution driven to the frame generator.
REQ-009 SHALL have port gen_sof  out  1  single-cycle start-of-frame to the frame generator.
REQ-010 SHALL have ports mon_tvalid, mon_tready, mon_tlast, mon_tuser  in  1  tap of the generator pixel stream.
REQ-011 SHALL have ports busy, frame_done, err_cfg, err_sync  out  1  status.
REQ-012 SHALL have port err_clr  in  1  clears sticky errors.
REQ-013 SHALL have ports frame_cnt, drop_cnt  out  CNT_W  statistics (see Configuration).

Function
REQ-014 SHALL implement states IDLE, LOAD, START, RUN; a beat is mon_tvalid && mon_tready.
REQ-015 IDLE: busy=0; frame_req && enable -> LOAD; frame_req with enable=0 SHALL be ignored and not counted.
REQ-016 LOAD: latch cfg_h_res/cfg_v_res into gen_h_res/gen_v_res (only update point); if either is 0, set err_cfg and -> IDLE without gen_sof; else -> START.
REQ-017 START: gen_sof=1 for exactly this cycle; clear pix_cnt/line_cnt; set first-beat flag; -> RUN.
REQ-018 Latency: frame_req in cycle N SHALL give gen_sof high in cycle N+2.
REQ-019 RUN: busy=1; each beat increments pix_cnt; beat with mon_tlast resets pix_cnt to 0 and increments line_cnt.
REQ-020 tlast beat with line_cnt == gen_v_res-1 SHALL pulse frame_done in the next cycle and return to IDLE.
REQ-021 err_sync SHALL set on: tuser beat not first beat of frame; first beat without tuser; tlast beat with pix_cnt != gen_h_res-1.
REQ-022 Errors SHALL NOT abort the frame; err_cfg/err_sync sticky until err_clr; set and err_clr in same cycle -> set wins.
REQ-023 frame_req during LOAD, START or RUN SHALL be dropped (never queued).
REQ-024 enable deasserted during RUN SHALL let the current frame complete; no new frame starts.
REQ-025 Comparisons SHALL use RES_W-bit unsigned arithmetic; counters wrap modulo 2^RES_W.

Reset
REQ-026 areset high at any clock edge, including mid-frame, SHALL force IDLE in the next cycle.
REQ-027 Reset values: busy=0, gen_sof=0, frame_done=0, err_cfg=0, err_sync=0, gen_h_res=0, gen_v_res=0, frame_cnt=0, drop_cnt=0, internal counters 0.

Configuration
REQ-028 Macro FRAME_CTRL_STATS_EN defined: frame_cnt increments on each frame_done; drop_cnt increments per dropped frame_req (REQ-023); both saturate at 2^CNT_W-1.
REQ-029 Macro FRAME_CTRL_STATS_EN undefined: frame_cnt and drop_cnt SHALL be constant 0 with no counter logic.

Verification
REQ-030 cfg 4x2, enable=1, frame_req pulse cycle 10 -> gen_sof cycle 12 only; 8 clean beats (tuser first, tlast every 4th) -> frame_done once, busy 0, no errors.
REQ-031 cfg_h_res=0, frame_req -> err_cfg=1, no gen_sof, IDLE; err_clr pulse -> err_cfg=0.
REQ-032 frame_req at cycles 11 and 15 during 4x2 frame -> both ignored, drop_cnt=2 (STATS_EN) or 0 (undefined); single frame_done.
REQ-033 cfg 4x2, tlast on 3rd beat of line 0 -> err_sync=1, frame still ends after 2nd tlast.
REQ-034 areset asserted mid-RUN for one cycle -> IDLE, all outputs at reset values; next frame_req starts a clean frame.
REQ-035 enable dropped mid-RUN -> frame completes with frame_done; later frame_req ignored, drop_cnt unchanged.

Source files
------------

// File: rtl/frame_ctrl.sv
// frame_ctrl: accepts frame requests from the timing generator, latches the
// requested resolution, issues a start-of-frame to the frame generator and
// monitors the generator's pixel stream for framing errors.
//
// Optional statistics (frame_cnt, drop_cnt) are built only when the macro
// FRAME_CTRL_STATS_EN is defined; otherwise both outputs are tied to zero.
//
// Ports
//   aclk, areset           clock, synchronous active-high reset
//   enable                 permits new frames to start
//   frame_req              single-cycle frame request
//   cfg_h_res, cfg_v_res   requested resolution
//   gen_h_res, gen_v_res   resolution latched for the current frame
//   gen_sof                single-cycle start-of-frame
//   mon_t*                 tap of the generator pixel stream
//   err_clr                clears the sticky error flags
//   busy, frame_done       status
//   err_cfg, err_sync      sticky error flags
//   frame_cnt, drop_cnt    saturating statistics counters
module frame_ctrl #(
  parameter int RES_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             enable,
  input  logic             frame_req,
  input  logic [RES_W-1:0] cfg_h_res,
  input  logic [RES_W-1:0] cfg_v_res,
  output logic [RES_W-1:0] gen_h_res,
  output logic [RES_W-1:0] gen_v_res,
  output logic             gen_sof,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  input  logic             mon_tuser,
  output logic             busy,
  output logic             frame_done,
  output logic             err_cfg,
  output logic             err_sync,
  input  logic             err_clr,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [RES_W-1:0] RES_ONE = RES_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [RES_W-1:0] pix_cnt;
  logic [RES_W-1:0] line_cnt;
  logic             first_beat;

  logic             beat;
  logic             cfg_bad;
  logic [RES_W-1:0] h_last;
  logic [RES_W-1:0] v_last;
  logic             sync_err_evt;
  logic             done_evt;

  assign beat   = mon_tvalid && mon_tready;
  assign h_last = gen_h_res - RES_ONE;
  assign v_last = gen_v_res - RES_ONE;

  // Next-state and combinational strobes
  always_comb begin
    state_nxt    = state;
    gen_sof      = 1'b0;
    busy         = (state != IDLE);
    done_evt     = 1'b0;
    sync_err_evt = 1'b0;
    cfg_bad      = (cfg_h_res == '0) || (cfg_v_res == '0);
    case (state)
      IDLE: begin
        if (frame_req && enable) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = cfg_bad ? IDLE : START;
      end
      START: begin
        gen_sof   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (beat) begin
          // Framing problems are flagged but never abort the frame.
          sync_err_evt = (mon_tuser && !first_beat) ||
                         (first_beat && !mon_tuser) ||
                         (mon_tlast && (pix_cnt != h_last));
          if (mon_tlast && (line_cnt == v_last)) begin
            done_evt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched resolution, counters and sticky flags
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      gen_h_res  <= '0;
      gen_v_res  <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      first_beat <= 1'b0;
      frame_done <= 1'b0;
      err_cfg    <= 1'b0;
      err_sync   <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= done_evt;

      // LOAD is the only point at which the generator resolution changes.
      if (state == LOAD) begin
        gen_h_res <= cfg_h_res;
        gen_v_res <= cfg_v_res;
      end

      if (state == START) begin
        pix_cnt    <= '0;
        line_cnt   <= '0;
        first_beat <= 1'b1;
      end else if ((state == RUN) && beat) begin
        first_beat <= 1'b0;
        if (mon_tlast) begin
          pix_cnt  <= '0;
          line_cnt <= line_cnt + RES_ONE;
        end else begin
          pix_cnt <= pix_cnt + RES_ONE;
        end
      end

      // A new error in the same cycle as err_clr keeps the flag set.
      if ((state == LOAD) && cfg_bad) err_cfg <= 1'b1;
      else if (err_clr)               err_cfg <= 1'b0;

      if (sync_err_evt)  err_sync <= 1'b1;
      else if (err_clr)  err_sync <= 1'b0;
    end
  end

`ifdef FRAME_CTRL_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic drop_evt;

  // Any request arriving outside IDLE is discarded, never queued.
  assign drop_evt = frame_req && (state != IDLE);

  always_ff @(posedge aclk) begin
    if (areset) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (frame_done && (frame_cnt != CNT_MAX)) frame_cnt <= frame_cnt + CNT_ONE;
      if (drop_evt && (drop_cnt != CNT_MAX))    drop_cnt  <= drop_cnt + CNT_ONE;
    end
  end
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_frame_ctrl.sv
// Self-checking bench for frame_ctrl. Expected start-of-frame cycles and the
// expected err_sync level at frame completion are queued when a frame is
// requested and checked when the DUT raises gen_sof / frame_done.
module tb_frame_ctrl;

  localparam int RES_W = 16;
  localparam int CNT_W = 32;

  logic             aclk = 1'b0;
  logic             areset;
  logic             enable;
  logic             frame_req;
  logic [RES_W-1:0] cfg_h_res;
  logic [RES_W-1:0] cfg_v_res;
  logic [RES_W-1:0] gen_h_res;
  logic [RES_W-1:0] gen_v_res;
  logic             gen_sof;
  logic             mon_tvalid;
  logic             mon_tready;
  logic             mon_tlast;
  logic             mon_tuser;
  logic             busy;
  logic             frame_done;
  logic             err_cfg;
  logic             err_sync;
  logic             err_clr;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] drop_cnt;

  frame_ctrl #(.RES_W(RES_W), .CNT_W(CNT_W)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .enable     (enable),
    .frame_req  (frame_req),
    .cfg_h_res  (cfg_h_res),
    .cfg_v_res  (cfg_v_res),
    .gen_h_res  (gen_h_res),
    .gen_v_res  (gen_v_res),
    .gen_sof    (gen_sof),
    .mon_tvalid (mon_tvalid),
    .mon_tready (mon_tready),
    .mon_tlast  (mon_tlast),
    .mon_tuser  (mon_tuser),
    .busy       (busy),
    .frame_done (frame_done),
    .err_cfg    (err_cfg),
    .err_sync   (err_sync),
    .err_clr    (err_clr),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int exp_frames = 0;
  int exp_drops  = 0;

  int sof_q[$];
  bit done_q[$];

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Output scoreboard, sampled on the falling edge.
  always @(negedge aclk) begin
    if (!areset) begin
      if (gen_sof) begin
        if (sof_q.size() == 0) check("sof_unexpected", 64'(cyc), 64'hFFFF_FFFF);
        else check("sof_cycle", 64'(cyc), 64'(sof_q.pop_front()));
      end
      if (frame_done) begin
        if (done_q.size() == 0) check("done_unexpected", 64'(cyc), 64'hFFFF_FFFF);
        else check("done_err_sync", 64'(err_sync), 64'(done_q.pop_front()));
      end
    end
  end

  function automatic logic [CNT_W-1:0] stat(input int v);
`ifdef FRAME_CTRL_STATS_EN
    return CNT_W'(v);
`else
    return '0;
`endif
  endfunction

  task automatic beats_off();
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
    mon_tuser  = 1'b0;
    frame_req  = 1'b0;
  endtask

  // Request a frame and stream it. Line 0 carries len0 beats, other lines h.
  // drop_load repeats the request during LOAD; drop_beat / en_off_beat name
  // the beat index at which an extra request / enable drop happens (-1 none).
  task automatic run_frame(input int h, input int v, input int len0,
                           input bit drop_load, input int drop_beat,
                           input int en_off_beat, input bit exp_err);
    int bi;
    int n;
    cfg_h_res = RES_W'(h);
    cfg_v_res = RES_W'(v);
    sof_q.push_back(cyc + 2);
    done_q.push_back(exp_err);
    frame_req = 1'b1;
    tick();
    frame_req = drop_load;
    if (drop_load) exp_drops++;
    tick();
    frame_req = 1'b0;
    tick();
    bi = 0;
    for (int l = 0; l < v; l++) begin
      n = (l == 0) ? len0 : h;
      for (int p = 0; p < n; p++) begin
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tuser  = (bi == 0);
        mon_tlast  = (p == n - 1);
        frame_req  = (bi == drop_beat);
        if (bi == drop_beat) exp_drops++;
        if (bi == en_off_beat) enable = 1'b0;
        tick();
        bi++;
      end
    end
    beats_off();
    exp_frames++;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset    = 1'b1;
    enable    = 1'b1;
    err_clr   = 1'b0;
    cfg_h_res = '0;
    cfg_v_res = '0;
    beats_off();
    repeat (3) tick();

    check("rst_busy",     64'(busy),       64'd0);
    check("rst_sof",      64'(gen_sof),    64'd0);
    check("rst_done",     64'(frame_done), 64'd0);
    check("rst_err_cfg",  64'(err_cfg),    64'd0);
    check("rst_err_sync", 64'(err_sync),   64'd0);
    check("rst_h_res",    64'(gen_h_res),  64'd0);
    check("rst_v_res",    64'(gen_v_res),  64'd0);
    check("rst_frames",   64'(frame_cnt),  64'd0);
    check("rst_drops",    64'(drop_cnt),   64'd0);
    areset = 1'b0;

    // Clean 4x2 frame requested in cycle 10.
    while (cyc < 10) tick();
    run_frame(4, 2, 4, 1'b0, -1, -1, 1'b0);
    check("clean_busy",     64'(busy),      64'd0);
    check("clean_err_sync", 64'(err_sync),  64'd0);
    check("clean_err_cfg",  64'(err_cfg),   64'd0);
    check("clean_h_res",    64'(gen_h_res), 64'd4);
    check("clean_v_res",    64'(gen_v_res), 64'd2);
    check("clean_frames",   64'(frame_cnt), 64'(stat(exp_frames)));

    // Zero horizontal resolution: error, no start-of-frame.
    cfg_h_res = '0;
    cfg_v_res = 16'd2;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    tick();
    check("cfg_err_set",  64'(err_cfg), 64'd1);
    tick();
    check("cfg_err_idle", 64'(busy),    64'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("cfg_err_clr",  64'(err_cfg), 64'd0);

    // Requests during LOAD and RUN are dropped.
    run_frame(4, 2, 4, 1'b1, 3, -1, 1'b0);
    check("drop_busy",   64'(busy),      64'd0);
    check("drop_cnt",    64'(drop_cnt),  64'(stat(exp_drops)));
    check("drop_frames", 64'(frame_cnt), 64'(stat(exp_frames)));

    // Early tlast on line 0: sync error, frame still ends on 2nd tlast.
    run_frame(4, 2, 3, 1'b0, -1, -1, 1'b1);
    check("sync_err_set", 64'(err_sync), 64'd1);
    check("sync_busy",    64'(busy),     64'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("sync_err_clr", 64'(err_sync), 64'd0);

    // Reset in the middle of a frame.
    cfg_h_res = 16'd4;
    cfg_v_res = 16'd2;
    sof_q.push_back(cyc + 2);
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    repeat (2) tick();
    for (int p = 0; p < 3; p++) begin
      mon_tvalid = 1'b1;
      mon_tready = 1'b1;
      mon_tuser  = (p == 0);
      mon_tlast  = 1'b0;
      tick();
    end
    beats_off();
    check("mid_busy", 64'(busy), 64'd1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    exp_frames = 0;
    exp_drops  = 0;
    check("mrst_busy",     64'(busy),       64'd0);
    check("mrst_done",     64'(frame_done), 64'd0);
    check("mrst_err_sync", 64'(err_sync),   64'd0);
    check("mrst_h_res",    64'(gen_h_res),  64'd0);
    check("mrst_v_res",    64'(gen_v_res),  64'd0);
    check("mrst_frames",   64'(frame_cnt),  64'd0);
    check("mrst_drops",    64'(drop_cnt),   64'd0);
    tick();
    check("mrst_sof", 64'(gen_sof), 64'd0);
    run_frame(4, 2, 4, 1'b0, -1, -1, 1'b0);
    check("post_rst_err_sync", 64'(err_sync),  64'd0);
    check("post_rst_frames",   64'(frame_cnt), 64'(stat(exp_frames)));

    // Enable dropped mid-frame: the frame completes, later requests ignored.
    run_frame(4, 2, 4, 1'b0, -1, 2, 1'b0);
    check("en_off_busy", 64'(busy), 64'd0);
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    repeat (4) tick();
    check("en_off_idle",   64'(busy),      64'd0);
    check("en_off_drops",  64'(drop_cnt),  64'(stat(exp_drops)));
    check("en_off_frames", 64'(frame_cnt), 64'(stat(exp_frames)));
    enable = 1'b1;

    check("sof_q_empty",  64'(sof_q.size()),  64'd0);
    check("done_q_empty", 64'(done_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
